// File: rtl/wallace_mult_pkg.sv
// Shared constants and helpers for the pipelined Wallace-tree multiplier.
// WALLACE_MULT_SIGNED_EN (see wallace_mult_pipe) selects the Baugh-Wooley signed build.
package wallace_mult_pkg;

  localparam int WIDTH_MIN  = 2;
  localparam int WIDTH_MAX  = 32;
  localparam int STAGES_MIN = 1;
  localparam int STAGES_MAX = 3;

  // Pipeline shapes: product registered straight from the inputs, operands
  // then final sum, or operands then sum/carry rows then final sum.
  localparam int STAGES_SINGLE = 1;
  localparam int STAGES_SPLIT  = 2;
  localparam int STAGES_ROWREG = 3;

  // Enough 3:2 levels to bring WIDTH_MAX+1 rows down to two.
  localparam int RED_LEVELS = 10;

  // Baugh-Wooley correction constant is 2^width + 2^(2*width-1), taken modulo
  // 2^(2*width); returned one bit at a time so callers need no wide temporaries.
  function automatic logic bw_corr_bit(input int width, input int pos);
    return (pos == width) || (pos == 2 * width - 1);
  endfunction

endpackage

// File: rtl/wallace_reduce.sv
// Partial-product generation and Wallace-tree reduction down to a sum row and
// a carry row; purely combinational, registers live in wallace_mult_pipe.
module wallace_reduce
  import wallace_mult_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               signed_mode,
  output logic [2*WIDTH-1:0] sum_row,
  output logic [2*WIDTH-1:0] carry_row
);

  localparam int PW = 2 * WIDTH;
  // WIDTH partial-product rows plus one correction row.
  localparam int NR = WIDTH + 1;
  // Two zero pad rows keep the grouped row indices in range for every group.
  localparam int NA = NR + 2;

  logic [PW-1:0] pp  [NA];
  logic [PW-1:0] cur [NA];
  logic [PW-1:0] nxt [NA];
  logic [PW-1:0] hs;
  logic [PW-1:0] hc;
  logic          pp_bit;
  int            cur_n;
  int            nxt_n;

  // Row i holds a & b[i] shifted left by i; in signed mode the terms that
  // involve exactly one sign bit are inverted and the constant row is added.
  always_comb begin
    pp_bit = 1'b0;
    for (int i = 0; i < NA; i++) begin
      pp[i] = '0;
    end
    for (int i = 0; i < WIDTH; i++) begin
      for (int j = 0; j < WIDTH; j++) begin
        pp_bit = a[j] & b[i];
        if (signed_mode && ((i == WIDTH - 1) != (j == WIDTH - 1))) begin
          pp_bit = ~pp_bit;
        end
        pp[i][i+j] = pp_bit;
      end
    end
    for (int k = 0; k < PW; k++) begin
      pp[WIDTH][k] = signed_mode & bw_corr_bit(WIDTH, k);
    end
  end

  // Each level takes rows in groups of three through full adders (two half
  // adders plus an OR); leftover rows of a group pass straight through.
  always_comb begin
    hs    = '0;
    hc    = '0;
    nxt_n = 0;
    for (int i = 0; i < NA; i++) begin
      cur[i] = pp[i];
      nxt[i] = '0;
    end
    cur_n = NR;
    for (int lvl = 0; lvl < RED_LEVELS; lvl++) begin
      if (cur_n > 2) begin
        nxt_n = 0;
        for (int i = 0; i < NA; i++) begin
          nxt[i] = '0;
        end
        for (int g = 0; g < NR; g += 3) begin
          if (g + 2 < cur_n) begin
            hs               = cur[g] ^ cur[g+1];
            hc               = cur[g] & cur[g+1];
            nxt[2*(g/3)]     = hs ^ cur[g+2];
            nxt[2*(g/3)+1]   = (hc | (hs & cur[g+2])) << 1;
            nxt_n            = nxt_n + 2;
          end else if (g + 1 < cur_n) begin
            nxt[2*(g/3)]     = cur[g];
            nxt[2*(g/3)+1]   = cur[g+1];
            nxt_n            = nxt_n + 2;
          end else if (g < cur_n) begin
            nxt[2*(g/3)]     = cur[g];
            nxt_n            = nxt_n + 1;
          end
        end
        for (int i = 0; i < NA; i++) begin
          cur[i] = nxt[i];
        end
        cur_n = nxt_n;
      end
    end
    sum_row   = cur[0];
    carry_row = cur[1];
  end

endmodule

// File: rtl/wallace_mult_pipe.sv
// Pipelined Wallace-tree multiplier with valid/ready handshake on both sides.
// Define WALLACE_MULT_SIGNED_EN to add signed_mode (Baugh-Wooley two's complement).
module wallace_mult_pipe
  import wallace_mult_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] p,
  output logic               busy
`ifdef WALLACE_MULT_SIGNED_EN
  ,
  input  logic               signed_mode
`endif
);

  // Handshake: a transfer happens on an edge where valid && ready. The whole
  // pipeline freezes (data and valid bits) only while the output is offered
  // and refused, so in_ready never depends on in_valid.
  logic              stall;
  logic              adv;
  logic              sm_in;
  logic [STAGES-1:0] vld;
  logic [2*WIDTH-1:0] sum_row;
  logic [2*WIDTH-1:0] carry_row;
  logic [2*WIDTH-1:0] p_q;

`ifdef WALLACE_MULT_SIGNED_EN
  assign sm_in = signed_mode;
`else
  assign sm_in = 1'b0;
`endif

  assign stall     = out_valid & ~out_ready;
  assign adv       = ~stall;
  assign in_ready  = ~stall;
  assign out_valid = vld[STAGES-1];
  assign busy      = |vld;
  assign p         = p_q;

  // Bubbles enter as zero valid bits and travel with the data.
  always_ff @(posedge clock) begin
    if (reset) begin
      vld <= '0;
    end else if (adv) begin
      vld[0] <= in_valid;
      for (int k = 1; k < STAGES; k++) begin
        vld[k] <= vld[k-1];
      end
    end
  end

  generate
    if (STAGES == STAGES_SINGLE) begin : g_single
      wallace_reduce #(.WIDTH(WIDTH)) u_reduce (
        .a           (a),
        .b           (b),
        .signed_mode (sm_in),
        .sum_row     (sum_row),
        .carry_row   (carry_row)
      );

      always_ff @(posedge clock) begin
        if (adv) begin
          p_q <= sum_row + carry_row;
        end
      end
    end else begin : g_multi
      logic [WIDTH-1:0] s1_a;
      logic [WIDTH-1:0] s1_b;
      logic             s1_sm;

      // signed_mode rides along with its operands.
      always_ff @(posedge clock) begin
        if (adv) begin
          s1_a  <= a;
          s1_b  <= b;
          s1_sm <= sm_in;
        end
      end

      wallace_reduce #(.WIDTH(WIDTH)) u_reduce (
        .a           (s1_a),
        .b           (s1_b),
        .signed_mode (s1_sm),
        .sum_row     (sum_row),
        .carry_row   (carry_row)
      );

      if (STAGES == STAGES_SPLIT) begin : g_split
        always_ff @(posedge clock) begin
          if (adv) begin
            p_q <= sum_row + carry_row;
          end
        end
      end else begin : g_rowreg
        logic [2*WIDTH-1:0] s2_sum;
        logic [2*WIDTH-1:0] s2_carry;

        always_ff @(posedge clock) begin
          if (adv) begin
            s2_sum   <= sum_row;
            s2_carry <= carry_row;
          end
        end

        // Final carry-propagate add over the registered rows.
        always_ff @(posedge clock) begin
          if (adv) begin
            p_q <= s2_sum + s2_carry;
          end
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_wallace_mult_pipe.sv
// Self-checking bench for wallace_mult_pipe: scoreboarded main instance
// (WIDTH=8, STAGES=2) plus WIDTH 2/16 x STAGES 1/3 latency sweeps.
module tb_wallace_mult_pipe;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Main instance
  logic        in_valid, in_ready, out_valid, out_ready, busy, sm;
  logic [7:0]  a, b;
  logic [15:0] p;

  wallace_mult_pipe #(.WIDTH(8), .STAGES(2)) u_dut (
    .clock(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .p(p), .busy(busy)
`ifdef WALLACE_MULT_SIGNED_EN
    , .signed_mode(sm)
`endif
  );

  // Sweep instances, always ready downstream
  logic        v2, v16, sm_off;
  logic [1:0]  a2, b2;
  logic [15:0] a16, b16;
  logic        r21, ov21, bz21, r23, ov23, bz23;
  logic        r161, ov161, bz161, r163, ov163, bz163;
  logic [3:0]  p21, p23;
  logic [31:0] p161, p163;

  wallace_mult_pipe #(.WIDTH(2), .STAGES(1)) u_w2s1 (
    .clock(clk), .reset(reset), .in_valid(v2), .in_ready(r21), .a(a2), .b(b2),
    .out_valid(ov21), .out_ready(1'b1), .p(p21), .busy(bz21)
`ifdef WALLACE_MULT_SIGNED_EN
    , .signed_mode(sm_off)
`endif
  );
  wallace_mult_pipe #(.WIDTH(2), .STAGES(3)) u_w2s3 (
    .clock(clk), .reset(reset), .in_valid(v2), .in_ready(r23), .a(a2), .b(b2),
    .out_valid(ov23), .out_ready(1'b1), .p(p23), .busy(bz23)
`ifdef WALLACE_MULT_SIGNED_EN
    , .signed_mode(sm_off)
`endif
  );
  wallace_mult_pipe #(.WIDTH(16), .STAGES(1)) u_w16s1 (
    .clock(clk), .reset(reset), .in_valid(v16), .in_ready(r161), .a(a16), .b(b16),
    .out_valid(ov161), .out_ready(1'b1), .p(p161), .busy(bz161)
`ifdef WALLACE_MULT_SIGNED_EN
    , .signed_mode(sm_off)
`endif
  );
  wallace_mult_pipe #(.WIDTH(16), .STAGES(3)) u_w16s3 (
    .clock(clk), .reset(reset), .in_valid(v16), .in_ready(r163), .a(a16), .b(b16),
    .out_valid(ov163), .out_ready(1'b1), .p(p163), .busy(bz163)
`ifdef WALLACE_MULT_SIGNED_EN
    , .signed_mode(sm_off)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [15:0] ref_mul(input logic [7:0] x, input logic [7:0] y, input logic s);
    logic signed [15:0] xs, ys;
    xs = {{8{x[7]}}, x};
    ys = {{8{y[7]}}, y};
    if (s) return xs * ys;
    return {8'd0, x} * {8'd0, y};
  endfunction

  // Main scoreboard: the driver pushes on acceptance, this monitor pops.
  logic [15:0] exp_q[$];
  int          main_out = 0;

  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
    end else if (out_valid && out_ready) begin
      main_out++;
      if (exp_q.size() == 0) check_eq("main_spurious", out_valid, 1'b0);
      else check_eq("main_p", p, exp_q.pop_front());
    end
  end

  // Sweep monitors check value and latency (stamp taken at acceptance).
  logic [3:0]  q21[$], q23[$];
  logic [31:0] q161[$], q163[$];
  int t21[$], t23[$], t161[$], t163[$];
  int n21 = 0, n23 = 0, n161 = 0, n163 = 0;

  always @(negedge clk) begin
    if (!reset) begin
      if (ov21) begin
        n21++;
        if (q21.size() == 0) check_eq("w2s1_spurious", ov21, 1'b0);
        else begin
          check_eq("w2s1_p", p21, q21.pop_front());
          check_eq("w2s1_latency", cyc - t21.pop_front(), 1);
        end
      end
      if (ov23) begin
        n23++;
        if (q23.size() == 0) check_eq("w2s3_spurious", ov23, 1'b0);
        else begin
          check_eq("w2s3_p", p23, q23.pop_front());
          check_eq("w2s3_latency", cyc - t23.pop_front(), 3);
        end
      end
      if (ov161) begin
        n161++;
        if (q161.size() == 0) check_eq("w16s1_spurious", ov161, 1'b0);
        else begin
          check_eq("w16s1_p", p161, q161.pop_front());
          check_eq("w16s1_latency", cyc - t161.pop_front(), 1);
        end
      end
      if (ov163) begin
        n163++;
        if (q163.size() == 0) check_eq("w16s3_spurious", ov163, 1'b0);
        else begin
          check_eq("w16s3_p", p163, q163.pop_front());
          check_eq("w16s3_latency", cyc - t163.pop_front(), 3);
        end
      end
      if (v2 && r21) begin q21.push_back({2'b00, a2} * {2'b00, b2}); t21.push_back(cyc); end
      if (v2 && r23) begin q23.push_back({2'b00, a2} * {2'b00, b2}); t23.push_back(cyc); end
      if (v16 && r161) begin q161.push_back({16'd0, a16} * {16'd0, b16}); t161.push_back(cyc); end
      if (v16 && r163) begin q163.push_back({16'd0, a16} * {16'd0, b16}); t163.push_back(cyc); end
    end
  end

  // Driver: called at posedge+1, returns at posedge+1 after the accepting edge.
  task automatic send(input logic [7:0] x, input logic [7:0] y, input logic s, input logic [15:0] e);
    int budget;
    a = x; b = y; sm = s; in_valid = 1'b1;
    budget = 0;
    @(negedge clk);
    while (!in_ready && budget < 50) begin
      budget++;
      @(negedge clk);
    end
    if (!in_ready) check_eq("send_accept", in_ready, 1'b1);
    else exp_q.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((exp_q.size() != 0 || busy) && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (k >= 50) check_eq("drain_timeout", exp_q.size(), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  int          cnt0, cyc0;
  logic [3:0]  idx4;
  logic [7:0]  rx, ry;
  logic        rs;

  initial begin
    reset = 1'b1; in_valid = 1'b1; a = 8'd1; b = 8'd1; sm = 1'b0; out_ready = 1'b1;
    v2 = 1'b0; v16 = 1'b0; a2 = '0; b2 = '0; a16 = '0; b16 = '0; sm_off = 1'b0;

    // Reset with in_valid high: nothing may be captured.
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check_eq("rst_out_valid", out_valid, 1'b0);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_in_ready", in_ready, 1'b1);
    @(posedge clk); #1;

    // 3*5: accepted in cycle 0, output in cycle 2.
    a = 8'd3; b = 8'd5; in_valid = 1'b1;
    @(negedge clk);
    check_eq("c0_in_ready", in_ready, 1'b1);
    check_eq("c0_out_valid", out_valid, 1'b0);
    exp_q.push_back(16'd15);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check_eq("c1_busy", busy, 1'b1);
    check_eq("c1_out_valid", out_valid, 1'b0);
    @(negedge clk);
    check_eq("c2_busy", busy, 1'b1);
    check_eq("c2_out_valid", out_valid, 1'b1);
    @(negedge clk);
    check_eq("c3_busy", busy, 1'b0);
    check_eq("c3_out_valid", out_valid, 1'b0);
    @(posedge clk); #1;

    // Corner value then 256 back-to-back random pairs.
    cnt0 = main_out;
    send(8'hFF, 8'hFF, 1'b0, 16'hFE01);
    cyc0 = cyc;
    for (int i = 0; i < 256; i++) begin
      rx = 8'($urandom_range(0, 255));
      ry = 8'($urandom_range(0, 255));
      send(rx, ry, 1'b0, ref_mul(rx, ry, 1'b0));
    end
    check_eq("tput_cycles", cyc - cyc0, 256);
    drain();
    check_eq("tput_count", main_out - cnt0, 257);

    // Stall with a full pipeline; a third pair waits on in_ready.
    cnt0 = main_out;
    out_ready = 1'b0;
    send(8'd10, 8'd20, 1'b0, 16'd200);
    send(8'd100, 8'd3, 1'b0, 16'd300);
    a = 8'd17; b = 8'd17; in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check_eq("stall_out_valid", out_valid, 1'b1);
      check_eq("stall_in_ready", in_ready, 1'b0);
      check_eq("stall_p_hold", p, 16'd200);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    send(8'd17, 8'd17, 1'b0, 16'd289);
    drain();
    check_eq("stall_count", main_out - cnt0, 3);

    // Reset after two transfers: only the later 7*9 may come out.
    cnt0 = main_out;
    send(8'd11, 8'd12, 1'b0, 16'd132);
    send(8'd13, 8'd14, 1'b0, 16'd182);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    a = 8'd7; b = 8'd9; in_valid = 1'b1;
    @(negedge clk);
    check_eq("flush_c0_out_valid", out_valid, 1'b0);
    check_eq("flush_c0_busy", busy, 1'b0);
    check_eq("flush_c0_in_ready", in_ready, 1'b1);
    exp_q.push_back(16'd63);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check_eq("flush_c1_out_valid", out_valid, 1'b0);
    @(negedge clk);
    check_eq("flush_c2_out_valid", out_valid, 1'b1);
    @(posedge clk); #1;
    drain();
    check_eq("flush_count", main_out - cnt0, 1);

`ifdef WALLACE_MULT_SIGNED_EN
    send(8'h80, 8'h80, 1'b1, 16'd16384);
    send(8'hFF, 8'h01, 1'b1, 16'hFFFF);
    send(8'hFF, 8'h01, 1'b0, 16'd255);
    for (int i = 0; i < 32; i++) begin
      rx = 8'($urandom_range(0, 255));
      ry = 8'($urandom_range(0, 255));
      rs = 1'($urandom_range(0, 1));
      send(rx, ry, rs, ref_mul(rx, ry, rs));
    end
    drain();
`endif

    // Width/depth sweep: exhaustive at WIDTH=2, random plus all-ones at 16.
    for (int i = 0; i < 16; i++) begin
      idx4 = 4'(i);
      a2 = idx4[3:2]; b2 = idx4[1:0]; v2 = 1'b1;
      a16 = (i == 0) ? 16'hFFFF : 16'($urandom_range(0, 65535));
      b16 = (i == 0) ? 16'hFFFF : 16'($urandom_range(0, 65535));
      v16 = 1'b1;
      @(posedge clk); #1;
    end
    v2 = 1'b0; v16 = 1'b0;
    repeat (6) @(posedge clk);
    #1;

    check_eq("main_q_empty", exp_q.size(), 0);
    check_eq("w2s1_count", n21, 16);
    check_eq("w2s3_count", n23, 16);
    check_eq("w16s1_count", n161, 16);
    check_eq("w16s3_count", n163, 16);
    check_eq("sweep_q_empty", q21.size() + q23.size() + q161.size() + q163.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
